// File: rtl/gpio_button_reader_pkg.sv
// rtl/gpio_button_reader_pkg.sv - shared defaults and board button indices
package gpio_pkg;

  localparam int NUM_BUTTONS_DEFAULT     = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 2000000;
  localparam int COUNT_WIDTH_DEFAULT     = 21;
  localparam int INDEX_WIDTH_DEFAULT     = 3;

  localparam int BTN_N = 0;
  localparam int BTN_S = 1;
  localparam int BTN_E = 2;
  localparam int BTN_W = 3;
  localparam int BTN_C = 4;

endpackage

// File: rtl/gpio_button_reader_if.sv
// rtl/gpio_button_reader_if.sv - press event valid/ready port
interface gpio_button_reader_if #(
  parameter int INDEX_WIDTH = 3
);

  logic                   evt_valid;
  logic [INDEX_WIDTH-1:0] evt_index;
  logic                   evt_ready;

  modport master (output evt_valid, output evt_index, input evt_ready);
  modport slave  (input evt_valid, input evt_index, output evt_ready);

endinterface

// File: rtl/gpio_button_reader_debounce.sv
// rtl/gpio_button_reader_debounce.sv - one button: 2-flop sync, hold counter, level and edge pulses
module button_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   sync1;
  logic                   sync2;
  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      count         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= sw;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      // Any sample agreeing with the current level restarts the hold window.
      if (sync2 == level) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        level         <= sync2;
        count         <= '0;
        press_pulse   <= sync2;
        release_pulse <= !sync2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_button_reader.sv
// rtl/gpio_button_reader.sv - debounced pushbuttons with a one-deep-per-button press event queue
module gpio_button_reader
  import gpio_pkg::*;
#(
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEFAULT,
  parameter int INDEX_WIDTH     = INDEX_WIDTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] gpio_sw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  gpio_button_reader_if.master   evt,
  output logic                   overflow
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .COUNT_WIDTH    (COUNT_WIDTH)
    ) u_debounce (
      .clock        (clock),
      .reset_n      (reset_n),
      .sw           (gpio_sw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] candidates;
  logic [NUM_BUTTONS-1:0] take_mask;
  logic [NUM_BUTTONS-1:0] pending_next;
  logic [INDEX_WIDTH-1:0] sel;
  logic                   load;
  logic                   lost;

  // A fresh press may go straight into an empty slot, so presses join the candidates.
  always_comb begin
    candidates = pending | btn_press;
    sel        = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (candidates[i]) sel = INDEX_WIDTH'(i);
    end
    load      = (!evt.evt_valid || evt.evt_ready) && (|candidates);
    take_mask = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      take_mask[i] = load && (sel == INDEX_WIDTH'(i));
    end
    // A press coinciding with its pending bit being loaded re-arms the bit.
    pending_next = (pending & ~take_mask) | (btn_press & ~(take_mask & ~pending));
    lost         = |(btn_press & pending & ~take_mask);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending       <= '0;
      evt.evt_valid <= 1'b0;
      evt.evt_index <= '0;
      overflow      <= 1'b0;
    end else begin
      pending <= pending_next;
      if (lost) overflow <= 1'b1;
      if (load) begin
        evt.evt_valid <= 1'b1;
        evt.evt_index <= sel;
      end else if (evt.evt_valid && evt.evt_ready) begin
        evt.evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpio_button_reader.sv
// tb/tb_gpio_button_reader.sv - vector table, directed corner sequences and random run against a window model
module tb_gpio_button_reader;

  localparam int NB = 5;
  localparam int DB = 8;
  localparam int CW = 4;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NB-1:0] gpio_sw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          overflow;

  always #5 clock = ~clock;

  gpio_button_reader_if #(.INDEX_WIDTH(IW)) evt_if ();

  gpio_button_reader #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DB),
    .COUNT_WIDTH    (CW),
    .INDEX_WIDTH    (IW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .gpio_sw    (gpio_sw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .evt        (evt_if),
    .overflow   (overflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: a level flips once the last DB synchronized samples all disagree with it.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_level, m_press, m_rel, m_pend;
  logic          m_valid, m_ovf;
  logic [IW-1:0] m_index;
  int            hold_left[NB];

  typedef struct {
    logic [NB-1:0] sw;
    logic          ready;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic          valid;
    logic [IW-1:0] index;
  } vec_t;
  vec_t vecs[12];

  task automatic check(string name, int actual, int expected);
    n_assert++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] prev_press;
    logic [NB-1:0] s;
    int            loaded;
    bit            all_diff;
    if (!reset_n) begin
      m_level = '0; m_press = '0; m_rel = '0; m_pend = '0;
      m_valid = 1'b0; m_index = '0; m_ovf = 1'b0;
      hist.delete();
      repeat (DB + 2) hist.push_back('0);
      return;
    end
    prev_press = m_press;
    loaded     = -1;
    if (!m_valid || evt_if.evt_ready) begin
      for (int i = NB - 1; i >= 0; i--) if (m_pend[i] || prev_press[i]) loaded = i;
    end
    if (loaded >= 0) begin
      m_valid = 1'b1;
      m_index = IW'(loaded);
    end else if (m_valid && evt_if.evt_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (i == loaded) begin
        if (m_pend[i]) m_pend[i] = prev_press[i];
      end else if (prev_press[i]) begin
        if (m_pend[i]) m_ovf = 1'b1;
        else m_pend[i] = 1'b1;
      end
    end
    hist.push_back(gpio_sw);
    if (hist.size() > DB + 2) void'(hist.pop_front());
    for (int i = 0; i < NB; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) begin
        s = hist[hist.size() - 3 - k];
        if (s[i] == m_level[i]) all_diff = 1'b0;
      end
      m_press[i] = all_diff && !m_level[i];
      m_rel[i]   = all_diff && m_level[i];
      if (all_diff) m_level[i] = ~m_level[i];
    end
  endtask

  task automatic step();
    logic [19:0] act, exp;
    @(posedge clock);
    model_edge();
    #1;
    act = {btn_level, btn_press, btn_release, evt_if.evt_valid, evt_if.evt_index, overflow};
    exp = {m_level, m_press, m_rel, m_valid, m_index, m_ovf};
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model at %0t: got %h expected %h", $time, act, exp);
    end
  endtask

  task automatic hold(int n);
    repeat (n) step();
  endtask

  initial begin
    int presses, rels, when, seen, bad;

    for (int r = 0; r < 9; r++) vecs[r] = '{5'b00100, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0};
    vecs[9]  = '{5'b00100, 1'b0, 5'b00100, 5'b00100, 1'b0, 3'd0};
    vecs[10] = '{5'b00100, 1'b0, 5'b00100, 5'b00000, 1'b1, 3'd2};
    vecs[11] = '{5'b00100, 1'b1, 5'b00100, 5'b00000, 1'b0, 3'd2};

    reset_n = 1'b0;
    gpio_sw = '0;
    evt_if.evt_ready = 1'b0;
    hold(3);
    check("reset_state", int'({btn_level, btn_press, btn_release, evt_if.evt_valid,
                               evt_if.evt_index, overflow}), 0);
    reset_n = 1'b1;
    hold(2);

    // press hold on channel 2, one row per clock edge
    for (int r = 0; r < 12; r++) begin
      gpio_sw = vecs[r].sw;
      evt_if.evt_ready = vecs[r].ready;
      step();
      check($sformatf("vec%0d_level", r), btn_level, vecs[r].level);
      check($sformatf("vec%0d_press", r), btn_press, vecs[r].press);
      check($sformatf("vec%0d_valid", r), evt_if.evt_valid, vecs[r].valid);
      check($sformatf("vec%0d_index", r), evt_if.evt_index, vecs[r].index);
    end
    gpio_sw = '0;
    evt_if.evt_ready = 1'b0;
    hold(12);

    // bounce on channel 0
    evt_if.evt_ready = 1'b1;
    presses = 0;
    when = -1;
    gpio_sw[0] = 1'b1;
    for (int s = 0; s < 5; s++) begin step(); if (btn_press[0]) presses++; end
    gpio_sw[0] = 1'b0;
    step();
    if (btn_press[0]) presses++;
    check("bounce_glitch_press", presses, 0);
    gpio_sw[0] = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (btn_press[0]) begin presses++; when = s; end
    end
    check("bounce_press_count", presses, 1);
    check("bounce_press_edge", when, 10);

    // release on channel 0 queues nothing
    evt_if.evt_ready = 1'b0;
    gpio_sw[0] = 1'b0;
    rels = 0; when = -1; seen = 0;
    for (int s = 1; s <= 14; s++) begin
      step();
      if (btn_release[0]) begin rels++; when = s; end
      if (evt_if.evt_valid) seen = 1;
    end
    check("release_count", rels, 1);
    check("release_edge", when, 10);
    check("release_no_event", seen, 0);
    check("release_level", btn_level[0], 0);

    // simultaneous presses 3 and 1 under backpressure
    gpio_sw[3] = 1'b1;
    gpio_sw[1] = 1'b1;
    seen = 0;
    for (int s = 0; s < 20 && !seen; s++) begin
      step();
      if (btn_press == 5'b01010) seen = 1;
    end
    check("prio_press_seen", seen, 1);
    step();
    check("prio_first_valid", evt_if.evt_valid, 1);
    check("prio_first_index", evt_if.evt_index, 1);
    bad = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (!(evt_if.evt_valid && evt_if.evt_index == 3'd1)) bad++;
    end
    check("prio_hold_stable", bad, 0);
    evt_if.evt_ready = 1'b1;
    step();
    check("prio_second_valid", evt_if.evt_valid, 1);
    check("prio_second_index", evt_if.evt_index, 3);
    step();
    check("prio_drained", evt_if.evt_valid, 0);
    evt_if.evt_ready = 1'b0;
    gpio_sw = '0;
    hold(12);

    // overflow on channel 4
    for (int p = 0; p < 3; p++) begin
      gpio_sw[4] = 1'b1;
      hold(12);
      if (p == 0) begin
        check("ovf_slot_valid", evt_if.evt_valid, 1);
        check("ovf_slot_index", evt_if.evt_index, 4);
      end
      check($sformatf("ovf_after_press%0d", p), overflow, (p == 2) ? 1 : 0);
      gpio_sw[4] = 1'b0;
      hold(12);
    end
    evt_if.evt_ready = 1'b1;
    hold(5);
    check("ovf_sticky", overflow, 1);
    reset_n = 1'b0;
    step();
    check("ovf_reset_clear", overflow, 0);
    reset_n = 1'b1;
    evt_if.evt_ready = 1'b0;
    hold(2);

    // reset in the middle of a debounce count
    gpio_sw[1] = 1'b1;
    hold(7);
    reset_n = 1'b0;
    hold(2);
    check("midreset_outputs", int'({btn_level, btn_press, btn_release, evt_if.evt_valid,
                                    evt_if.evt_index, overflow}), 0);
    reset_n = 1'b1;
    when = -1;
    for (int s = 1; s <= 15; s++) begin
      step();
      if (btn_press[1] && when < 0) when = s;
    end
    check("midreset_press_edge", when, 10);

    // random bouncing inputs, random backpressure, rare resets
    reset_n = 1'b0;
    gpio_sw = '0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          gpio_sw[i] = 1'($urandom_range(0, 1));
          hold_left[i] = $urandom_range(1, 20);
        end else begin
          hold_left[i]--;
        end
      end
      evt_if.evt_ready = ($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
